// File: rtl/pchb_sched_pkg.sv
// Shared types and constants for the PCHB adder scheduler.
//   state_t     : FSM state code (IDLE, ISSUE, WAIT_ACK, RESP, RECOVER)
//   RECOVER_CYC : cycles add_reset is held high during recovery
//   WD_W        : watchdog counter width
package pchb_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t ISSUE    = 3'd1;
  localparam state_t WAIT_ACK = 3'd2;
  localparam state_t RESP     = 3'd3;
  localparam state_t RECOVER  = 3'd4;

  localparam int unsigned RECOVER_CYC = 2;
  localparam int unsigned WD_W        = 16;

endpackage

// File: rtl/pchb_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after ptr,
// wrapping around.
//   req     : request vector
//   ptr     : search start index
//   grant_c : one-hot winner (zero when nothing requests)
//   idx_c   : winner index
//   valid_c : a winner exists
module pchb_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant_c,
  output logic [IW-1:0]    idx_c,
  output logic             valid_c
);

  // Walk the ring from ptr; the first hit wins.
  always_comb begin
    int unsigned   pos;
    logic [IW-1:0] pos_idx;
    grant_c = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      pos_idx = IW'(pos);
      if (!valid_c && req[pos_idx]) begin
        valid_c          = 1'b1;
        idx_c            = pos_idx;
        grant_c[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pchb_add_scheduler.sv
// Shares one asynchronous PCHB adder among N_REQ synchronous requesters.
// Round-robin arbitration, registered operands, four-phase handshakes on both
// sides, and a watchdog that recovers a stalled adder through add_reset.
//   clk, reset         : clock, async active-high reset
//   req_i/ack_o        : per-requester four-phase handshake
//   a_i, b_i           : packed operands, requester k at [k*WIDTH +: WIDTH]
//   sum_o, err_o       : result and watchdog-recovery flag, valid with ack_o
//   add_req/add_ack    : adder four-phase handshake (add_ack is asynchronous)
//   add_a, add_b       : registered adder operands
//   add_sum            : adder result, stable while add_ack is high
//   add_en, add_reset  : adder enable and reset
module pchb_add_scheduler
  import pchb_sched_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] a_i,
  input  logic [N_REQ*WIDTH-1:0] b_i,
  output logic [N_REQ-1:0]       ack_o,
  output logic [WIDTH-1:0]       sum_o,
  output logic                   err_o,
  output logic                   add_req,
  input  logic                   add_ack,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  input  logic [WIDTH-1:0]       add_sum,
  output logic                   add_en,
  output logic                   add_reset
);

  localparam int unsigned    IW       = $clog2(N_REQ);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] REC_LAST = WD_W'(RECOVER_CYC - 1);

  state_t                 state_q, state_d;
  logic [N_REQ-1:0]       grant_oh_q, grant_oh_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   rec_err_q, rec_err_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  logic [N_REQ-1:0] ack_d;
  logic [WIDTH-1:0] sum_d, add_a_d, add_b_d;
  logic             err_d, add_req_d, add_en_d, add_reset_d;
  logic             wd_inc;

  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;

  pchb_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req     (req_i),
    .ptr     (ptr_q),
    .grant_c (pick_grant),
    .idx_c   (pick_idx),
    .valid_c (pick_valid)
  );

  // add_ack synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= add_ack;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_oh_q <= '0;
      ptr_q      <= '0;
      wd_q       <= '0;
      rec_err_q  <= 1'b0;
      ack_o      <= '0;
      sum_o      <= '0;
      err_o      <= 1'b0;
      add_req    <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      add_en     <= 1'b0;
      add_reset  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_oh_q <= grant_oh_d;
      ptr_q      <= ptr_d;
      wd_q       <= wd_d;
      rec_err_q  <= rec_err_d;
      ack_o      <= ack_d;
      sum_o      <= sum_d;
      err_o      <= err_d;
      add_req    <= add_req_d;
      add_a      <= add_a_d;
      add_b      <= add_b_d;
      add_en     <= add_en_d;
      add_reset  <= add_reset_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d     = state_q;
    grant_oh_d  = grant_oh_q;
    ptr_d       = ptr_q;
    rec_err_d   = rec_err_q;
    ack_d       = ack_o;
    sum_d       = sum_o;
    err_d       = err_o;
    add_a_d     = add_a;
    add_b_d     = add_b;
    wd_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_oh_d = pick_grant;
          ptr_d      = (32'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + IW'(1);
          add_a_d    = a_i[32'(pick_idx)*WIDTH +: WIDTH];
          add_b_d    = b_i[32'(pick_idx)*WIDTH +: WIDTH];
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        wd_inc = 1'b1;
        if (ack_s) begin
          sum_d     = add_sum;
          ack_d     = grant_oh_q;
          err_d     = 1'b0;
          rec_err_d = 1'b0;
          state_d   = RESP;
        end else if (wd_q == WD_LAST) begin
          // Dead adder: the requester gets a zero result flagged as an error.
          sum_d     = '0;
          rec_err_d = 1'b1;
          state_d   = RECOVER;
        end
      end
      RESP: begin
        // Only a stuck-high adder ack is timed; a slow requester is not.
        wd_inc = ack_s;
        if (((req_i & grant_oh_q) == '0) && !ack_s) begin
          ack_d   = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end else if (ack_s && (wd_q == WD_LAST)) begin
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        wd_inc = 1'b1;
        if (wd_q == REC_LAST) begin
          ack_d   = grant_oh_q;
          err_d   = rec_err_q;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) wd_d = '0;
    else if (wd_inc)        wd_d = wd_q + WD_W'(1);
    else                    wd_d = wd_q;

    // Adder-side outputs follow the state being entered.
    add_req_d   = (state_d == WAIT_ACK);
    add_en_d    = (state_d == ISSUE) || (state_d == WAIT_ACK) || (state_d == RESP);
    add_reset_d = (state_d == RECOVER);
  end

endmodule

// File: tb/tb_pchb_add_scheduler.sv
// Self-checking bench for pchb_add_scheduler with a behavioural adder and a
// round-robin reference model.
module tb_pchb_add_scheduler;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] a_i, b_i;
  logic [N-1:0]   ack_o;
  logic [W-1:0]   sum_o;
  logic           err_o, add_req;
  logic           add_ack = 1'b0;
  logic [W-1:0]   add_a, add_b;
  logic [W-1:0]   add_sum = '0;
  logic           add_en, add_reset;

  int n_checks = 0;
  int n_fail   = 0;

  // adder behaviour: 0 normal, 1 dead, 2 ack stuck high until add_reset
  int mode    = 0;
  int ack_dly = 1;
  int acnt    = 0;

  always #5 clk = ~clk;

  pchb_add_scheduler #(.N_REQ(N), .WIDTH(W), .SYNC_STAGES(2), .TIMEOUT_CYC(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .ack_o     (ack_o),
    .sum_o     (sum_o),
    .err_o     (err_o),
    .add_req   (add_req),
    .add_ack   (add_ack),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_en    (add_en),
    .add_reset (add_reset)
  );

  // Behavioural asynchronous adder, reacting shortly after each clock edge.
  always @(posedge clk) begin
    #1;
    if (add_reset) begin
      add_ack = 1'b0;
      acnt    = 0;
    end else if (mode == 1) begin
      add_ack = 1'b0;
      acnt    = 0;
    end else if (add_req && !add_ack) begin
      acnt = acnt + 1;
      if (acnt >= ack_dly) begin
        add_sum = W'((int'(add_a) + int'(add_b)) % 16);
        add_ack = 1'b1;
      end
    end else if (!add_req) begin
      if (mode != 2) add_ack = 1'b0;
      acnt = 0;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    req_i = '0;
    a_i   = '0;
    b_i   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ack_rise(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (ack_o != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ack_fall(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (ack_o == '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({ack_o, sum_o, err_o, add_req, add_a, add_b, add_en, add_reset} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: ack_o=%b sum_o=%h err_o=%b add_req=%b add_a=%h add_b=%h add_en=%b add_reset=%b, want all 0",
               ack_o, sum_o, err_o, add_req, add_a, add_b, add_en, add_reset);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({add_en, add_req, ack_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: add_en=%b add_req=%b ack_o=%b, want 0", add_en, add_req, ack_o);
    end
  endtask

  task automatic test_single();
    bit ok;
    mode = 0; ack_dly = 1;
    @(negedge clk);
    req_i = 4'b0010; a_i[4 +: 4] = 4'h3; b_i[4 +: 4] = 4'h5;
    @(posedge clk); #1;
    n_checks++;
    if (add_a !== 4'h3 || add_b !== 4'h5 || add_en !== 1'b1 || add_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_edge1: add_a=%h add_b=%h add_en=%b add_req=%b, want 3 5 1 0", add_a, add_b, add_en, add_req);
    end
    @(posedge clk); #1;
    n_checks++;
    if (add_req !== 1'b1) begin
      n_fail++;
      $display("FAIL single_edge2: add_req=%b, want 1", add_req);
    end
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (ack_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_edge4: ack_o=%b, want 0000", ack_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ack_o !== 4'b0010 || sum_o !== 4'h8 || add_req !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_edge5: ack_o=%b sum_o=%h add_req=%b err_o=%b, want 0010 8 0 0", ack_o, sum_o, add_req, err_o);
    end
    @(negedge clk);
    req_i = 4'b0000;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (ack_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_hold_while_ack_s: ack_o=%b, want 0010", ack_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ack_o !== 4'b0000 || add_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: ack_o=%b add_en=%b, want 0000 0", ack_o, add_en);
    end
    ok = 1'b1;
  endtask

  task automatic test_wrap();
    bit ok;
    @(negedge clk);
    req_i = 4'b0100; a_i[8 +: 4] = 4'hF; b_i[8 +: 4] = 4'h2;
    wait_ack_rise(30, ok);
    n_checks++;
    if (!ok || ack_o !== 4'b0100 || sum_o !== 4'h1 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: seen=%b ack_o=%b sum_o=%h err_o=%b, want 0100 1 0", ok, ack_o, sum_o, err_o);
    end
    @(negedge clk); req_i = '0;
    wait_ack_fall(30, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wrap_close: ack_o=%b stayed high, want 0000", ack_o); end
  endtask

  task automatic test_dead();
    bit ok;
    int cnt_req, cnt_rst;
    bit bad_en;
    cnt_req = 0; cnt_rst = 0; bad_en = 1'b0; ok = 1'b0;
    @(negedge clk);
    mode = 1;
    req_i = 4'b1000; a_i[12 +: 4] = 4'h9; b_i[12 +: 4] = 4'h9;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (add_req) cnt_req++;
      if (add_reset) begin cnt_rst++; if (add_en) bad_en = 1'b1; end
      if (ack_o != '0) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || cnt_req != 64 || cnt_rst != 2 || bad_en) begin
      n_fail++;
      $display("FAIL dead_timing: seen=%b add_req_cycles=%0d add_reset_cycles=%0d en_in_recover=%b, want 1 64 2 0",
               ok, cnt_req, cnt_rst, bad_en);
    end
    n_checks++;
    if (ack_o !== 4'b1000 || sum_o !== 4'h0 || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL dead_result: ack_o=%b sum_o=%h err_o=%b, want 1000 0 1", ack_o, sum_o, err_o);
    end
    @(negedge clk); mode = 0; req_i = '0;
    wait_ack_fall(30, ok);
    n_checks++;
    if (!ok || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL dead_close: closed=%b err_o=%b, want 1 0", ok, err_o);
    end
  endtask

  task automatic test_stuck();
    bit ok, dropped;
    int hi, rc;
    @(negedge clk);
    mode = 2; ack_dly = 1;
    req_i = 4'b0001; a_i[0 +: 4] = 4'h7; b_i[0 +: 4] = 4'h6;
    wait_ack_rise(30, ok);
    n_checks++;
    if (!ok || ack_o !== 4'b0001 || sum_o !== 4'hD || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_first: seen=%b ack_o=%b sum_o=%h err_o=%b, want 0001 d 0", ok, ack_o, sum_o, err_o);
    end
    @(negedge clk); req_i = '0;
    hi = 1; dropped = 1'b0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (add_reset) begin ok = 1'b1; break; end
      if (ack_o == 4'b0001) hi++;
      else dropped = 1'b1;
    end
    n_checks++;
    if (!ok || hi != 64 || dropped) begin
      n_fail++;
      $display("FAIL stuck_timeout: recovered=%b resp_cycles=%0d ack_dropped=%b, want 1 64 0", ok, hi, dropped);
    end
    n_checks++;
    if (ack_o !== 4'b0001 || sum_o !== 4'hD) begin
      n_fail++;
      $display("FAIL stuck_keep: ack_o=%b sum_o=%h, want 0001 d", ack_o, sum_o);
    end
    rc = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (add_reset) rc++;
      else break;
    end
    n_checks++;
    if (rc != 2 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_reset_pulse: add_reset_cycles=%0d err_o=%b, want 2 0", rc, err_o);
    end
    wait_ack_fall(30, ok);
    n_checks++;
    if (!ok || add_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_close: closed=%b add_reset=%b, want 1 0", ok, add_reset);
    end
    @(negedge clk); mode = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(negedge clk);
    mode = 1;
    req_i = 4'b0100; a_i[8 +: 4] = 4'h1; b_i[8 +: 4] = 4'h1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (add_req) begin ok = 1'b1; break; end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (!ok || {add_req, ack_o, add_en, sum_o, err_o, add_reset} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: reached_wait=%b add_req=%b ack_o=%b add_en=%b sum_o=%h err_o=%b add_reset=%b, want 1 then all 0",
               ok, add_req, ack_o, add_en, sum_o, err_o, add_reset);
    end
    req_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mode = 0; ack_dly = 1;
    @(negedge clk);
    req_i = 4'b1010;
    a_i[4 +: 4] = 4'h2; b_i[4 +: 4] = 4'h2;
    a_i[12 +: 4] = 4'h5; b_i[12 +: 4] = 4'h5;
    wait_ack_rise(30, ok);
    n_checks++;
    if (!ok || ack_o !== 4'b0010 || sum_o !== 4'h4) begin
      n_fail++;
      $display("FAIL reset_ptr: seen=%b ack_o=%b sum_o=%h, want 0010 4", ok, ack_o, sum_o);
    end
    @(negedge clk); req_i = '0;
    wait_ack_fall(30, ok);
    repeat (3) @(posedge clk);
  endtask

  task automatic test_contention();
    bit ok;
    int order [5];
    logic [N-1:0] exp_oh;
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];
    order = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < N; k++) begin
      opa[k] = W'($urandom); opb[k] = W'($urandom);
      a_i[k*W +: W] = opa[k]; b_i[k*W +: W] = opb[k];
    end
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack_rise(40, ok);
      exp_oh = '0; exp_oh[order[i]] = 1'b1;
      n_checks++;
      if (!ok || ack_o !== exp_oh || sum_o !== W'((int'(opa[order[i]]) + int'(opb[order[i]])) % 16)) begin
        n_fail++;
        $display("FAIL contention_%0d: seen=%b ack_o=%b sum_o=%h, want %b %h", i, ok, ack_o, sum_o, exp_oh,
                 W'((int'(opa[order[i]]) + int'(opb[order[i]])) % 16));
      end
      @(negedge clk); req_i[order[i]] = 1'b0;
      wait_ack_fall(40, ok);
      @(negedge clk);
      opa[order[i]] = W'($urandom); opb[order[i]] = W'($urandom);
      a_i[order[i]*W +: W] = opa[order[i]]; b_i[order[i]*W +: W] = opb[order[i]];
      req_i[order[i]] = 1'b1;
    end
    // Pointer sits at 2 after granting 1; requesters 0 and 1 must wrap to 0.
    do_reset();
    req_i = 4'b0010;
    wait_ack_rise(40, ok);
    @(negedge clk); req_i = '0;
    wait_ack_fall(40, ok);
    @(negedge clk);
    req_i = 4'b0011;
    wait_ack_rise(40, ok);
    n_checks++;
    if (!ok || ack_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL ptr_wrap: seen=%b ack_o=%b, want 0001", ok, ack_o);
    end
    @(negedge clk); req_i = '0;
    wait_ack_fall(40, ok);
  endtask

  task automatic test_random();
    bit ok;
    int p, eg, k0;
    logic [N-1:0] pend, exp_oh;
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];
    logic [W-1:0] exp_sum;
    do_reset();
    p = 0; pend = '0;
    for (int k = 0; k < N; k++) begin opa[k] = '0; opb[k] = '0; end
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      ack_dly = int'($urandom_range(1, 4));
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && ($urandom_range(0, 2) == 0)) begin
          opa[k] = W'($urandom); opb[k] = W'($urandom); pend[k] = 1'b1;
        end
      end
      if (pend == '0) begin
        k0 = int'($urandom_range(0, N - 1));
        opa[k0] = W'($urandom); opb[k0] = W'($urandom); pend[k0] = 1'b1;
      end
      for (int k = 0; k < N; k++) begin
        a_i[k*W +: W] = opa[k]; b_i[k*W +: W] = opb[k];
      end
      req_i = pend;
      eg = 0;
      for (int i = 0; i < N; i++) begin
        if (pend[(p + i) % N]) begin eg = (p + i) % N; break; end
      end
      exp_oh = '0; exp_oh[eg] = 1'b1;
      exp_sum = W'((int'(opa[eg]) + int'(opb[eg])) % 16);
      wait_ack_rise(60, ok);
      n_checks++;
      if (!ok || ack_o !== exp_oh || sum_o !== exp_sum || err_o !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d: seen=%b ack_o=%b sum_o=%h err_o=%b, want %b %h 0", it, ok, ack_o, sum_o, err_o, exp_oh, exp_sum);
      end
      p = (eg + 1) % N;
      @(negedge clk);
      pend[eg] = 1'b0;
      req_i = pend;
      wait_ack_fall(60, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL random_close_%0d: ack_o=%b, want 0000", it, ack_o);
      end
    end
    @(negedge clk); req_i = '0;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req_i = '0;
    a_i   = '0;
    b_i   = '0;
    test_reset();
    test_single();
    test_wrap();
    test_dead();
    test_stuck();
    test_reset_mid();
    test_contention();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pchb_add_scheduler.md
# pchb_add_scheduler

Clocked scheduler that shares one asynchronous PCHB 4-bit adder among N synchronous requesters. It arbitrates round-robin and registers the granted operands onto the adder inputs. It runs the adder's four-phase req/ack handshake through a synchronizer, then returns the sum to the winner over a four-phase handshake. A watchdog recovers the adder through its reset if the handshake stalls.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 4, operand/sum width; must match the adder
- SYNC_STAGES, 2, flops on the add_ack synchronizer
- TIMEOUT_CYC, 64, watchdog limit in clk cycles; 16-bit counter
- clk  in  1  scheduler clock
- reset  in  1  reset, asynchronous, active-high
- req_i  in  N_REQ  per-requester request, level, four-phase
- a_i  in  N_REQ*WIDTH  packed operand A, requester k at [k*WIDTH +: WIDTH]
- b_i  in  N_REQ*WIDTH  packed operand B, same packing
- ack_o  out  N_REQ  per-requester acknowledge, one-hot or zero
- sum_o  out  WIDTH  result, valid while any ack_o bit is high
- err_o  out  1  high with ack_o when the result came from watchdog recovery (sum_o=0)
- add_req  out  1  adder request
- add_ack  in  1  adder acknowledge, asynchronous
- add_a, add_b  out  WIDTH  registered adder operands
- add_sum  in  WIDTH  adder sum, stable while add_ack high
- add_en  out  1  adder enable
- add_reset  out  1  adder reset, active-high

## Operation
- Reset values: ack_o=0, sum_o=0, err_o=0, add_req=0, add_a=add_b=0, add_en=0, add_reset=0, rr pointer=0, state=IDLE, watchdog=0.
- Reset mid-operation drops every output immediately. The adder is not reset by the scheduler's reset; add_reset is asserted only from RECOVER.
- add_ack passes through SYNC_STAGES flops; ack_s is the synchronized value. req_i, a_i and b_i are synchronous and are not synchronized.
- Arbitration: round-robin. The search starts at pointer p and the lowest index at or after p wins, with wrap-around. After a grant, p = grant+1 mod N_REQ.
- FSM:
  - IDLE: if any req_i, latch grant g and load add_a/add_b from requester g; -> ISSUE.
  - ISSUE: add_en=1, operand setup cycle; -> WAIT_ACK.
  - WAIT_ACK: add_req=1, add_en=1, watchdog counts.
    - On ack_s=1: capture add_sum into sum_o; -> RESP.
    - On watchdog==TIMEOUT_CYC-1: -> RECOVER.
  - RESP: add_req=0, ack_o[g]=1, add_en stays 1. Exit to IDLE when req_i[g]=0 and ack_s=0; ack_o[g] drops on that edge. The watchdog counts cycles with ack_s still 1 after entry; on expiry -> RECOVER.
  - RECOVER: add_req=0, add_en=0, add_reset=1 for 2 cycles.
    - Entered from WAIT_ACK: sum_o=0, err_o=1; -> RESP.
    - Entered from RESP: the already-captured sum and ack_o are kept; -> RESP.
- Watchdog clears on every state change.
- Requester rule: a_i/b_i are held stable from req rise until ack_o rise. The scheduler samples operands once, in IDLE.
- A requester that drops req_i before ack_o rises is unsupported. The scheduler completes the transaction; ack_o then drops on the first RESP cycle with ack_s=0.
- Simultaneous requests: the rr pointer decides. A request arriving during a transaction waits; no request is lost while it stays high.
- sum_o is WIDTH bits, modulo 2^WIDTH. No carry-out.

## Timing
- req_i[k] seen high at edge 0 with idle FSM: grant and operands at edge 1, add_req high at edge 2.
- If add_ack rises before edge 3: ack_s high at edge 2+SYNC_STAGES, sum_o and ack_o at the following edge. Minimum req→ack is 5 edges with SYNC_STAGES=2.
- add_req falls on the same edge ack_o rises.
- Back-to-back: the next grant happens in the IDLE cycle after ack_o falls. There is a minimum of 1 idle cycle between transactions.
- Watchdog: WAIT_ACK lasts at most TIMEOUT_CYC cycles, then 2 RECOVER cycles.

## Structure
- Package pchb_sched_pkg: state enum (IDLE, ISSUE, WAIT_ACK, RESP, RECOVER), RECOVER_CYC=2, watchdog width constant.
- Sub-module pchb_rr_pick: combinational round-robin picker with inputs req vector and pointer, outputs one-hot grant, index and valid.
- Synchronizer is inline flops in the top level.

## Test plan
- Single request: k=1, a=4'h3, b=4'h5, adder acks after 1 cycle -> ack_o=4'b0010, sum_o=4'h8 at edge 5; ack_o falls after req_i[1] falls and ack_s=0.
- Wrap: a=4'hF, b=4'h2 -> sum_o=4'h1, err_o=0.
- Contention: req_i=4'b1111 held -> grant order 0,1,2,3,0. Pointer at 2 with req_i=4'b0011 -> grant 0.
- Dead adder: add_ack tied 0 -> add_req high 64 cycles, add_reset high 2 cycles, then ack_o[g]=1, sum_o=0, err_o=1.
- Stuck ack: add_ack tied 1 after first use -> RESP times out after 64 cycles, add_reset pulses 2 cycles, then the transaction closes normally.
- Reset asserted in WAIT_ACK -> add_req, ack_o, add_en, sum_o all 0 immediately. After release, a new req is granted from pointer 0.
